// File: rtl/ex_stage.sv
// Execute stage: one-cycle ALU/multiply, 32-step radix-2 restoring divider, registered MEM bundle.
// Optional misaligned-address check is enabled by defining EX_ALE_CHECK_EN.
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        excp_flush,
  input  logic        ertn_flush,
  input  logic        left_valid,
  output logic        left_ready,
  output logic        right_valid,
  input  logic        right_ready,
  output logic        is_fire,
  input  logic        fire,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_inst,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [31:0] store_data,
  input  logic [3:0]  alu_op,
  input  logic [2:0]  md_op,
  input  logic [5:0]  op_mem,
  input  logic [4:0]  wreg_index,
  input  logic        wreg_en,
  input  logic        inst_valid,
  input  logic        id_excp_valid,
  input  logic [6:0]  id_excp_code,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_inst,
  output logic [31:0] ex_result,
  output logic [31:0] ex_store_data,
  output logic [5:0]  ex_op_mem,
  output logic [4:0]  ex_wreg_index,
  output logic        ex_wreg_en,
  output logic        ex_inst_valid,
  output logic        ex_excp_valid,
  output logic [6:0]  ex_excp_code,
  output logic [37:0] ex_bypass,
  output logic        ex_is_load,
  output logic        div_busy
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} div_state_t;

  div_state_t  state, state_nxt;
  logic [4:0]  count;
  logic [31:0] quo, rem, dvs;
  logic        neg_q, neg_r;

  logic        flush, logic_valid, capture, excp_out, ale, fwd_en;
  logic [31:0] alu_res, md_res, result, div_res;
  logic [4:0]  shamt;

  assign flush = excp_flush | ertn_flush;
  assign shamt = src2[4:0];

  always_comb begin
    alu_res = 32'h0;
    case (alu_op)
      4'd0:  alu_res = src1 + src2;
      4'd1:  alu_res = src1 - src2;
      4'd2:  alu_res = {31'h0, $signed(src1) < $signed(src2)};
      4'd3:  alu_res = {31'h0, src1 < src2};
      4'd4:  alu_res = src1 & src2;
      4'd5:  alu_res = src1 | src2;
      4'd6:  alu_res = ~(src1 | src2);
      4'd7:  alu_res = src1 ^ src2;
      4'd8:  alu_res = src1 << shamt;
      4'd9:  alu_res = src1 >> shamt;
      4'd10: alu_res = $signed(src1) >>> shamt;
      4'd11: alu_res = src2;
      default: alu_res = 32'h0;
    endcase
  end

  // 33-bit sign/zero extension realised as 64-bit operands; the low 64 bits of the product are exact.
  logic        mul_sx;
  logic [63:0] mul_a, mul_b, prod;
  assign mul_sx = (md_op == 3'd2);
  assign mul_a  = {{32{mul_sx & src1[31]}}, src1};
  assign mul_b  = {{32{mul_sx & src2[31]}}, src2};
  assign prod   = mul_a * mul_b;

  // Divider operand preparation: magnitudes for signed ops, raw values otherwise.
  logic        div_signed, a_neg, b_neg;
  logic [31:0] abs_a, abs_b;
  assign div_signed = ~md_op[1];
  assign a_neg      = div_signed & src1[31];
  assign b_neg      = div_signed & src2[31];
  assign abs_a      = a_neg ? (~src1 + 32'd1) : src1;
  assign abs_b      = b_neg ? (~src2 + 32'd1) : src2;

  // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic        step_ge;
  assign rem_sh  = {rem, quo[31]};
  assign diff    = {1'b0, rem_sh} - {2'b00, dvs};
  assign step_ge = ~diff[33];

  assign div_res = md_op[0] ? (neg_r ? (~rem + 32'd1) : rem)
                            : (neg_q ? (~quo + 32'd1) : quo);

  always_comb begin
    md_res = div_res;
    if (!md_op[2]) md_res = (md_op == 3'd1) ? prod[31:0] : prod[63:32];
  end

  assign result = (md_op == 3'd0) ? alu_res : md_res;

`ifdef EX_ALE_CHECK_EN
  assign ale = op_mem[0] & ((op_mem[3] & (result[1:0] != 2'b00)) | (op_mem[4] & result[0]));
`else
  assign ale = 1'b0;
`endif

  assign excp_out    = id_excp_valid | ale;
  assign logic_valid = left_valid & ~(md_op[2] & (state != S_DONE));
  assign is_fire     = logic_valid & right_ready;
  assign left_ready  = is_fire | ~left_valid;
  assign capture     = is_fire & ~flush;
  assign fwd_en      = wreg_en & logic_valid & ~excp_out;
  assign ex_bypass   = {result, wreg_index, fwd_en};
  assign ex_is_load  = left_valid & op_mem[0] & ~op_mem[2];
  assign div_busy    = (state == S_DIV);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (left_valid & md_op[2] & ~flush) state_nxt = S_DIV;
      S_DIV:  if (flush) state_nxt = S_IDLE;
              else if (count == 5'd31) state_nxt = S_DONE;
      S_DONE: if (flush | is_fire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      count <= 5'd0;
      quo   <= 32'h0;
      rem   <= 32'h0;
      dvs   <= 32'h0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && state_nxt == S_DIV) begin
        quo   <= abs_a;
        dvs   <= abs_b;
        rem   <= 32'h0;
        count <= 5'd0;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
      end else if (state == S_DIV) begin
        rem   <= step_ge ? diff[31:0] : rem_sh[31:0];
        quo   <= {quo[30:0], step_ge};
        count <= count + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) right_valid <= 1'b0;
    else if (flush) right_valid <= 1'b0;
    else right_valid <= (fire ? 1'b0 : right_valid) | is_fire;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_pc         <= 32'h0;
      ex_inst       <= 32'h0;
      ex_result     <= 32'h0;
      ex_store_data <= 32'h0;
      ex_op_mem     <= 6'h0;
      ex_wreg_index <= 5'h0;
      ex_wreg_en    <= 1'b0;
      ex_inst_valid <= 1'b0;
      ex_excp_valid <= 1'b0;
      ex_excp_code  <= 7'h0;
    end else if (capture) begin
      ex_pc         <= id_pc;
      ex_inst       <= id_inst;
      ex_result     <= result;
      ex_store_data <= store_data;
      ex_op_mem     <= {op_mem[5:1], op_mem[0] & ~excp_out};
      ex_wreg_index <= wreg_index;
      ex_wreg_en    <= wreg_en & ~excp_out;
      ex_inst_valid <= inst_valid;
      ex_excp_valid <= excp_out;
      ex_excp_code  <= id_excp_valid ? id_excp_code : (ale ? 7'h09 : 7'h00);
    end
  end

endmodule
